// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, oversampled by s_tick, mid-bit sampling with start-bit glitch rejection
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_tick,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       frame_err
);
  localparam int SW = $clog2(OVERSAMPLE);
  localparam logic [SW-1:0] HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [SW-1:0] s;
  logic [2:0]    n;
  logic [7:0]    b;
  logic          rx_m, rx_s;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      s         <= '0;
      n         <= '0;
      b         <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_done <= 1'b0;
      case (state)
        IDLE: if (!rx_s) begin
          state <= START;
          s     <= '0;
        end
        START: if (s_tick) begin
          if (s == HALF) begin
            // a start bit that is high again at mid-bit was only a glitch
            state <= rx_s ? IDLE : DATA;
            s     <= '0;
            n     <= '0;
          end else s <= s + 1'b1;
        end
        DATA: if (s_tick) begin
          if (s == LAST) begin
            s <= '0;
            b <= {rx_s, b[7:1]};
            if (n == 3'd7) state <= STOP;
            else n <= n + 1'b1;
          end else s <= s + 1'b1;
        end
        STOP: if (s_tick) begin
          if (s == LAST) begin
            s         <= '0;
            dout      <= b;
            frame_err <= ~rx_s;
            rx_done   <= 1'b1;
            state     <= IDLE;
          end else s <= s + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames, glitch, framing error, mid-frame reset and a 256-byte serial loopback
module tb_uart_rx;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       rx_done, frame_err;
  int tests = 0, fails = 0;
  int tick_div = 4, tcnt = 0;
  int done_cnt = 0, fe_cnt = 0, dbl = 0;
  logic prev_done = 1'b0;

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done(rx_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    s_tick <= (tcnt == 0);
    tcnt   <= (tcnt >= tick_div - 1) ? 0 : tcnt + 1;
  end

  always @(negedge clk) begin
    if (rx_done) begin
      done_cnt++;
      if (frame_err) fe_cnt++;
      if (prev_done) dbl++;
    end
    prev_done = rx_done;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    repeat (k) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk) rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rx = d[i];
      wait_ticks(16);
    end
    @(negedge clk) rx = stop;
    wait_ticks(16);
    @(negedge clk) rx = 1'b1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d, input logic fe);
    int c0;
    c0 = done_cnt;
    send_frame(d, ~fe);
    chk({tag, " done"}, done_cnt - c0, 1);
    chk({tag, " dout"}, dout, d);
    chk({tag, " ferr"}, frame_err, fe);
  endtask

  initial begin
    int c0, f0;
    repeat (3) @(negedge clk);
    chk("rst dout", dout, 8'h00);
    chk("rst done", rx_done, 1'b0);
    chk("rst ferr", frame_err, 1'b0);
    rst = 1'b0;
    wait_ticks(20);
    chk("idle no done", done_cnt, 0);

    expect_frame("a5", 8'hA5, 1'b0);
    chk("a5 pulse width", dbl, 0);

    expect_frame("b2b 00", 8'h00, 1'b0);
    expect_frame("b2b ff", 8'hFF, 1'b0);

    c0 = done_cnt;
    @(negedge clk) rx = 1'b0;
    wait_ticks(3);
    @(negedge clk) rx = 1'b1;
    wait_ticks(24);
    chk("glitch no done", done_cnt - c0, 0);
    chk("glitch dout held", dout, 8'hFF);
    expect_frame("post glitch 3c", 8'h3C, 1'b0);

    c0 = done_cnt;
    send_frame(8'h5A, 1'b0);
    chk("ferr done", done_cnt - c0, 1);
    chk("ferr dout", dout, 8'h5A);
    chk("ferr flag", frame_err, 1'b1);
    wait_ticks(24);
    chk("break glitch no done", done_cnt - c0, 1);
    expect_frame("clean 11", 8'h11, 1'b0);

    c0 = done_cnt;
    @(negedge clk) rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk) rx = 8'hC3 >> i;
      wait_ticks(16);
    end
    @(negedge clk) rx = 1'b0;
    wait_ticks(8);
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rx = 1'b1;
    chk("mid rst dout", dout, 8'h00);
    chk("mid rst done", rx_done, 1'b0);
    chk("mid rst ferr", frame_err, 1'b0);
    @(negedge clk) rst = 1'b0;
    wait_ticks(200);
    chk("aborted no done", done_cnt - c0, 0);
    chk("after rst dout", dout, 8'h00);
    expect_frame("post rst 7e", 8'h7E, 1'b0);

    @(negedge clk) tick_div = 1;
    wait_ticks(20);
    c0 = done_cnt;
    f0 = fe_cnt;
    for (int v = 0; v < 256; v++) begin
      send_frame(8'(v), 1'b1);
      chk("loop dout", dout, v);
    end
    chk("loop done count", done_cnt - c0, 256);
    chk("loop ferr count", fe_cnt - f0, 0);
    chk("pulse width total", dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial UART receiver paired with the team's existing uart_tx. It oversamples the asynchronous rx line using the shared baud-rate s_tick strobe and recovers 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit. Each received byte is presented on dout with a one-cycle rx_done strobe and a framing-error flag. It sits between the board-level rx pin and the host-side byte consumer (FIFO or register interface).

Parameters:
OVERSAMPLE, 16, s_tick pulses per bit period. Must be even and ≥ 4. Must match the value the transmitter uses.

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
s_tick  input  1  single-cycle oversample strobe, OVERSAMPLE per bit period
rx  input  1  raw asynchronous serial line; idle high
dout  output  8  last received data byte
rx_done  output  1  one-cycle pulse when a frame completes
frame_err  output  1  stop-bit status of the last frame; 1 = stop bit sampled low

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: dout = 8'h00, rx_done = 0, frame_err = 0, state = IDLE, all counters 0, both synchronizer flops = 1.
- Input sync: rx passes through a 2-flop synchronizer to produce rx_s. Only rx_s is used internally. This adds 2 clk of latency.
- Counters:
  - s: $clog2(OVERSAMPLE) bits; counts only on s_tick.
  - n: 3 bits; counts data bits.
  - b: 8-bit shift register.
- State IDLE:
  - rx_s == 0 → go to START, s = 0.
  - s_tick is not required for this transition.
- State START (s_tick cycles only):
  - s == OVERSAMPLE/2-1 and rx_s == 0 → go to DATA, s = 0, n = 0. This is the mid-bit confirmation.
  - s == OVERSAMPLE/2-1 and rx_s == 1 → glitch. Return to IDLE; no rx_done, no output change.
  - Otherwise s = s + 1.
- State DATA (s_tick cycles only):
  - s == OVERSAMPLE-1 → b = {rx_s, b[7:1]} (LSB first), s = 0.
    - n == 7 → go to STOP.
    - Otherwise n = n + 1.
  - Otherwise s = s + 1.
- State STOP (s_tick cycles only):
  - s == OVERSAMPLE-1 → dout = b, frame_err = ~rx_s, rx_done = 1 for exactly one clk, go to IDLE.
  - Otherwise s = s + 1.
- Registered outputs:
  - dout and frame_err are registered and update only in the rx_done cycle.
  - They hold their values between frames.
  - A frame with a framing error still updates dout and asserts rx_done.
- Latency: from the first s_tick after rx_s falls to rx_done is OVERSAMPLE/2 + 9·OVERSAMPLE ticks (152 ticks at 16).
- Sampling points:
  - Data bits are sampled at mid-bit.
  - The stop bit is sampled one full bit period after the mid-point of the last data bit.
- Back-to-back frames: after STOP the FSM is in IDLE on the next clk. A start edge immediately following the stop sample is accepted.
- Break handling: if rx_s is still low in IDLE after a framing error, it is treated as a new start bit. That frame will then itself be glitch-checked.
- s_tick in the same cycle as a state entry: the entering state does not consume it. Counting begins on the next s_tick.
- rst mid-frame: immediately abort to IDLE and return all outputs to their reset values. No partial byte is ever presented.

Test Plan:
1. Frame 0xA5, line idle high, OVERSAMPLE = 16, s_tick every 4 clk → rx_done pulses once, dout = 8'hA5, frame_err = 0, rx_done high for exactly 1 clk.
2. Back-to-back frames 0x00 then 0xFF with no idle gap → two rx_done pulses; dout = 8'h00, then 8'hFF; frame_err = 0 both times.
3. rx low for 3 ticks, then high (glitch) → FSM returns to IDLE; no rx_done; dout unchanged. A following valid 0x3C frame is received correctly.
4. Frame 0x5A with the stop bit driven low → rx_done pulses, dout = 8'h5A, frame_err = 1. The next clean frame 0x11 clears frame_err to 0.
5. rst asserted during data bit 4 of a 0xC3 frame, then a clean 0x7E frame → no rx_done for the aborted frame; dout = 8'h00 after reset, then 8'h7E.
6. Loopback: uart_tx.tx connected to uart_rx.rx, sharing s_tick, bytes 0x00–0xFF sent → every byte matches, with 256 rx_done pulses and frame_err never set.
